id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register for the 16-bit WISC core; sits directly downstream of the register file's two read ports.
- Captures SrcData1/SrcData2 plus decode control each cycle.
- Applies same-cycle write-back bypass (a write and a read of one register in one cycle returns the new value).
- Supports stall (hold) and flush (bubble), keeps held operands coherent with write-back during stalls, and counts bubbles for performance monitoring.

Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_ADDR_W, 4, register specifier width (16 registers)
- OPC_W, 4, opcode width
- ZERO_REG, 1, when 1 register 0 always reads 0x0000 and is never bypassed or refreshed
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold all EX-side state this cycle
- flush  in  1  load a bubble this cycle; overrides stall
- id_valid  in  1  decode stage presents a real instruction
- id_opcode  in  OPC_W  decoded opcode
- id_src_reg1, id_src_reg2  in  REG_ADDR_W  source specifiers, also driving the register file read decoders
- id_dst_reg  in  REG_ADDR_W  destination specifier
- id_write_reg  in  1  instruction writes a register
- id_imm  in  DATA_W  sign-extended immediate
- id_pc_plus2  in  DATA_W  PC+2 of the instruction
- rf_src_data1, rf_src_data2  in  DATA_W  register file read data
- wb_write_reg  in  1  write-back enable, the same signal that drives the register file
- wb_dst_reg  in  REG_ADDR_W  write-back register
- wb_dst_data  in  DATA_W  write-back data
- ex_valid  out  1  EX stage holds a real instruction
- ex_opcode, ex_src_reg1, ex_src_reg2, ex_dst_reg, ex_write_reg, ex_imm, ex_pc_plus2  out  (widths as the id_ inputs)  registered copies
- ex_op_a, ex_op_b  out  DATA_W  registered operands
- bubble_count  out  CNT_W  saturating count of bubble loads

Behaviour:
- Reset: asynchronous, on rst high. Every output goes to 0, including ex_valid=0, ex_write_reg=0 and bubble_count=0. Outputs stay 0 until the first rising edge after rst falls.
- Priority at each rising edge, highest first: rst, then flush, then stall, then load.
- Operand select, combinational, for source n (n = 1 or 2):
  - If ZERO_REG=1 and id_src_regn == 0: the operand is 0.
  - Else if wb_write_reg=1 and wb_dst_reg == id_src_regn: the operand is wb_dst_data.
  - Else: the operand is rf_src_datan.
- Load (no flush, no stall): all ex_ fields take their id_ inputs; ex_op_a and ex_op_b take the selected operands; ex_valid takes id_valid.
  - If id_valid=0, the load is a bubble.
- Bubble (flush=1, or a load with id_valid=0):
  - ex_valid=0, ex_write_reg=0, all other fields 0.
  - bubble_count increments by 1 and saturates at all-ones.
- Stall (no flush): all fields hold their values, with one exception. Operand refresh: if wb_write_reg=1, wb_dst_reg == ex_src_reg1 and (ZERO_REG=0 or ex_src_reg1 != 0), ex_op_a takes wb_dst_data. ex_op_b refreshes the same way against ex_src_reg2. bubble_count holds.
- A stall with ex_valid=0 holds the bubble and does not increment bubble_count.
- Simultaneous flush and stall: flush wins and bubble_count increments.
- Latency: one cycle from id_ inputs to ex_ outputs; no combinational path from inputs to outputs.
- Reset mid-stall or mid-flush: reset wins immediately; no pending state survives it.
- Write-back data equal to the existing register value: no special case; bypass still selects wb_dst_data.

Decomposition:
- Shared package wisc_pkg holds:
  - DATA_W, REG_ADDR_W and OPC_W constants
  - the zero-register index constant
  - the NOP/bubble encoding constant (all-zero control)
- Sub-module operand_bypass_mux: combinational, instantiated twice, once per source. Inputs are the specifier, the rf data and the wb triple; output is the selected operand. The refresh path uses the same sub-module, instantiated twice with the ex_ specifiers.

Test Plan:
- Reset: rst pulsed asynchronously mid-cycle with valid inputs present -> all outputs 0 immediately; after release, first load of id_opcode=4'h2, rf_src_data1=16'h1234 -> ex_op_a=16'h1234, ex_valid=1 one cycle later.
- Bypass: id_src_reg1=3, rf_src_data1=16'hAAAA, wb_write_reg=1, wb_dst_reg=3, wb_dst_data=16'h5555 -> ex_op_a=16'h5555; with wb_dst_reg=4 instead -> ex_op_a=16'hAAAA.
- Zero register: id_src_reg2=0, rf_src_data2=16'hFFFF, wb write to r0 with 16'h7777 -> ex_op_b=16'h0000.
- Stall refresh: load with src1=5 and op_a=16'h0001, then stall 3 cycles with a wb write to r5 of 16'h0BEE in the second stall cycle -> ex_op_a=16'h0BEE from the next edge; all other fields unchanged; bubble_count unchanged.
- Flush over stall: flush=1 and stall=1 together with ex_valid=1 -> ex_valid=0, ex_write_reg=0, bubble_count increments 0 to 1; then id_valid=0 for 2 cycles -> bubble_count=3.
- Saturation: CNT_W=2, 5 consecutive flushes -> bubble_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC core constants: datapath widths, the hardwired-zero register and the bubble encoding.
package wisc_pkg;

  localparam int unsigned DataW    = 16;
  localparam int unsigned RegAddrW = 4;
  localparam int unsigned OpcW     = 4;

  // Register that reads as zero when the zero-register option is enabled
  localparam int unsigned ZeroRegIdx = 0;

  // A bubble carries all-zero control: invalid, no write-back, opcode 0
  localparam logic            NopValid    = 1'b0;
  localparam logic            NopWriteReg = 1'b0;
  localparam logic [OpcW-1:0] NopOpcode   = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode/execute boundary bundle: ID-side inputs, register file and write-back taps, EX-side outputs.
interface id_ex_stage_reg_if
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W     = DataW,
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned OPC_W      = OpcW,
  parameter int unsigned CNT_W      = 16
);

  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [OPC_W-1:0]      id_opcode;
  logic [REG_ADDR_W-1:0] id_src_reg1;
  logic [REG_ADDR_W-1:0] id_src_reg2;
  logic [REG_ADDR_W-1:0] id_dst_reg;
  logic                  id_write_reg;
  logic [DATA_W-1:0]     id_imm;
  logic [DATA_W-1:0]     id_pc_plus2;
  logic [DATA_W-1:0]     rf_src_data1;
  logic [DATA_W-1:0]     rf_src_data2;
  logic                  wb_write_reg;
  logic [REG_ADDR_W-1:0] wb_dst_reg;
  logic [DATA_W-1:0]     wb_dst_data;

  logic                  ex_valid;
  logic [OPC_W-1:0]      ex_opcode;
  logic [REG_ADDR_W-1:0] ex_src_reg1;
  logic [REG_ADDR_W-1:0] ex_src_reg2;
  logic [REG_ADDR_W-1:0] ex_dst_reg;
  logic                  ex_write_reg;
  logic [DATA_W-1:0]     ex_imm;
  logic [DATA_W-1:0]     ex_pc_plus2;
  logic [DATA_W-1:0]     ex_op_a;
  logic [DATA_W-1:0]     ex_op_b;
  logic [CNT_W-1:0]      bubble_count;

  // Pipeline control / decode side
  modport master (
    output stall, flush, id_valid, id_opcode, id_src_reg1, id_src_reg2, id_dst_reg,
           id_write_reg, id_imm, id_pc_plus2, rf_src_data1, rf_src_data2,
           wb_write_reg, wb_dst_reg, wb_dst_data,
    input  ex_valid, ex_opcode, ex_src_reg1, ex_src_reg2, ex_dst_reg, ex_write_reg,
           ex_imm, ex_pc_plus2, ex_op_a, ex_op_b, bubble_count
  );

  // The stage register itself
  modport slave (
    input  stall, flush, id_valid, id_opcode, id_src_reg1, id_src_reg2, id_dst_reg,
           id_write_reg, id_imm, id_pc_plus2, rf_src_data1, rf_src_data2,
           wb_write_reg, wb_dst_reg, wb_dst_data,
    output ex_valid, ex_opcode, ex_src_reg1, ex_src_reg2, ex_dst_reg, ex_write_reg,
           ex_imm, ex_pc_plus2, ex_op_a, ex_op_b, bubble_count
  );

endinterface

// File: rtl/operand_bypass_mux.sv
// Selects one operand: hardwired zero, same-cycle write-back data, or the supplied read data.
module operand_bypass_mux
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W     = DataW,
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] src_reg_i,
  input  logic [DATA_W-1:0]     rf_data_i,
  input  logic                  wb_write_reg_i,
  input  logic [REG_ADDR_W-1:0] wb_dst_reg_i,
  input  logic [DATA_W-1:0]     wb_dst_data_i,
  output logic [DATA_W-1:0]     operand_o
);

  localparam logic [REG_ADDR_W-1:0] ZeroIdx = REG_ADDR_W'(ZeroRegIdx);

  // Zero register beats bypass; bypass beats the register file read
  always_comb begin
    operand_o = rf_data_i;
    if (ZERO_REG && (src_reg_i == ZeroIdx)) begin
      operand_o = '0;
    end else if (wb_write_reg_i && (wb_dst_reg_i == src_reg_i)) begin
      operand_o = wb_dst_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with write-back bypass, stall hold with operand refresh,
// flush-to-bubble and a saturating bubble counter.
module id_ex_stage_reg
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W     = DataW,
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned OPC_W      = OpcW,
  parameter bit          ZERO_REG   = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input logic                clk,
  input logic                rst,
  id_ex_stage_reg_if.slave   bus
);

  logic                  valid_q, valid_d;
  logic [OPC_W-1:0]      opcode_q, opcode_d;
  logic [REG_ADDR_W-1:0] src1_q, src1_d;
  logic [REG_ADDR_W-1:0] src2_q, src2_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic                  write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0]     pc_plus2_q, pc_plus2_d;
  logic [DATA_W-1:0]     op_a_q, op_a_d;
  logic [DATA_W-1:0]     op_b_q, op_b_d;
  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

  logic [DATA_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] refresh_a, refresh_b;
  logic              load_bubble;

  // Operand selection for the instruction entering EX
  operand_bypass_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_bypass_a (
    .src_reg_i      (bus.id_src_reg1),
    .rf_data_i      (bus.rf_src_data1),
    .wb_write_reg_i (bus.wb_write_reg),
    .wb_dst_reg_i   (bus.wb_dst_reg),
    .wb_dst_data_i  (bus.wb_dst_data),
    .operand_o      (sel_a)
  );

  operand_bypass_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_bypass_b (
    .src_reg_i      (bus.id_src_reg2),
    .rf_data_i      (bus.rf_src_data2),
    .wb_write_reg_i (bus.wb_write_reg),
    .wb_dst_reg_i   (bus.wb_dst_reg),
    .wb_dst_data_i  (bus.wb_dst_data),
    .operand_o      (sel_b)
  );

  // Refresh of held operands: the "read data" is the currently held value, so a miss holds.
  // A held zero-register operand is already 0, so the zero case also preserves it.
  operand_bypass_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_refresh_a (
    .src_reg_i      (src1_q),
    .rf_data_i      (op_a_q),
    .wb_write_reg_i (bus.wb_write_reg),
    .wb_dst_reg_i   (bus.wb_dst_reg),
    .wb_dst_data_i  (bus.wb_dst_data),
    .operand_o      (refresh_a)
  );

  operand_bypass_mux #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_refresh_b (
    .src_reg_i      (src2_q),
    .rf_data_i      (op_b_q),
    .wb_write_reg_i (bus.wb_write_reg),
    .wb_dst_reg_i   (bus.wb_dst_reg),
    .wb_dst_data_i  (bus.wb_dst_data),
    .operand_o      (refresh_b)
  );

  // Flush always bubbles; otherwise an unstalled load of an invalid instruction bubbles
  assign load_bubble = bus.flush || (!bus.stall && !bus.id_valid);

  // Next-state: bubble, stall-hold with refresh, or normal load
  always_comb begin
    valid_d      = valid_q;
    opcode_d     = opcode_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    dst_d        = dst_q;
    write_reg_d  = write_reg_q;
    imm_d        = imm_q;
    pc_plus2_d   = pc_plus2_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    bubble_cnt_d = bubble_cnt_q;

    if (load_bubble) begin
      valid_d     = NopValid;
      opcode_d    = OPC_W'(NopOpcode);
      src1_d      = '0;
      src2_d      = '0;
      dst_d       = '0;
      write_reg_d = NopWriteReg;
      imm_d       = '0;
      pc_plus2_d  = '0;
      op_a_d      = '0;
      op_b_d      = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else if (bus.stall) begin
      // A held bubble stays an all-zero bubble
      if (valid_q) begin
        op_a_d = refresh_a;
        op_b_d = refresh_b;
      end
    end else begin
      valid_d     = bus.id_valid;
      opcode_d    = bus.id_opcode;
      src1_d      = bus.id_src_reg1;
      src2_d      = bus.id_src_reg2;
      dst_d       = bus.id_dst_reg;
      write_reg_d = bus.id_write_reg;
      imm_d       = bus.id_imm;
      pc_plus2_d  = bus.id_pc_plus2;
      op_a_d      = sel_a;
      op_b_d      = sel_b;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      opcode_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      dst_q        <= '0;
      write_reg_q  <= 1'b0;
      imm_q        <= '0;
      pc_plus2_q   <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      opcode_q     <= opcode_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      dst_q        <= dst_d;
      write_reg_q  <= write_reg_d;
      imm_q        <= imm_d;
      pc_plus2_q   <= pc_plus2_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_opcode    = opcode_q;
  assign bus.ex_src_reg1  = src1_q;
  assign bus.ex_src_reg2  = src2_q;
  assign bus.ex_dst_reg   = dst_q;
  assign bus.ex_write_reg = write_reg_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_pc_plus2  = pc_plus2_q;
  assign bus.ex_op_a      = op_a_q;
  assign bus.ex_op_b      = op_b_q;
  assign bus.bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, bypass, zero register, stall refresh,
// flush-over-stall and counter saturation (second instance with a 2-bit counter).
module tb_id_ex_stage_reg;
  import wisc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_stage_reg_if #(.CNT_W(16)) bus  ();
  id_ex_stage_reg_if #(.CNT_W(2))  bus2 ();

  id_ex_stage_reg #(.ZERO_REG(1'b1), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_ex_stage_reg #(.ZERO_REG(1'b1), .CNT_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_default();
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.id_valid     = 1'b1;
    bus.id_opcode    = 4'h1;
    bus.id_src_reg1  = 4'd1;
    bus.id_src_reg2  = 4'd2;
    bus.id_dst_reg   = 4'd3;
    bus.id_write_reg = 1'b1;
    bus.id_imm       = 16'h0010;
    bus.id_pc_plus2  = 16'h0100;
    bus.rf_src_data1 = 16'h1111;
    bus.rf_src_data2 = 16'h2222;
    bus.wb_write_reg = 1'b0;
    bus.wb_dst_reg   = 4'd0;
    bus.wb_dst_data  = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_default();
    bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.id_valid = 1'b1; bus2.id_opcode = 4'h1;
    bus2.id_src_reg1 = 4'd1; bus2.id_src_reg2 = 4'd2; bus2.id_dst_reg = 4'd3;
    bus2.id_write_reg = 1'b1; bus2.id_imm = 16'h0; bus2.id_pc_plus2 = 16'h0;
    bus2.rf_src_data1 = 16'h0; bus2.rf_src_data2 = 16'h0;
    bus2.wb_write_reg = 1'b0; bus2.wb_dst_reg = 4'd0; bus2.wb_dst_data = 16'h0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 16'h1111) begin
      errors++;
      $display("FAIL pre_reset_load: valid=%b op_a=%h, want valid=1 op_a=1111",
               bus.ex_valid, bus.ex_op_a);
    end
    // Assert reset mid-cycle while the clock is high; outputs must clear without an edge
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_op_a !== 16'h0 || bus.ex_op_b !== 16'h0 ||
        bus.ex_opcode !== 4'h0 || bus.ex_write_reg !== 1'b0 || bus.ex_imm !== 16'h0 ||
        bus.ex_pc_plus2 !== 16'h0 || bus.ex_dst_reg !== 4'h0 ||
        bus.ex_src_reg1 !== 4'h0 || bus.bubble_count !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b op_a=%h op_b=%h opc=%h wr=%b imm=%h bc=%h, want all 0",
               bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_opcode, bus.ex_write_reg,
               bus.ex_imm, bus.bubble_count);
    end
    step();
    rst = 1'b0;
    bus.id_opcode    = 4'h2;
    bus.rf_src_data1 = 16'h1234;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_op_a !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b op_a=%h, want 0 0", bus.ex_valid, bus.ex_op_a);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op_a !== 16'h1234 || bus.ex_opcode !== 4'h2) begin
      errors++;
      $display("FAIL first_load: valid=%b op_a=%h opc=%h, want 1 1234 2",
               bus.ex_valid, bus.ex_op_a, bus.ex_opcode);
    end
    checks++;
    if (bus.ex_op_b !== 16'h2222 || bus.ex_dst_reg !== 4'd3 || bus.ex_imm !== 16'h0010 ||
        bus.ex_pc_plus2 !== 16'h0100 || bus.ex_write_reg !== 1'b1) begin
      errors++;
      $display("FAIL first_load_fields: op_b=%h dst=%h imm=%h pc=%h wr=%b, want 2222 3 0010 0100 1",
               bus.ex_op_b, bus.ex_dst_reg, bus.ex_imm, bus.ex_pc_plus2, bus.ex_write_reg);
    end
  endtask

  task automatic test_bypass();
    drive_default();
    bus.id_src_reg1  = 4'd3;
    bus.rf_src_data1 = 16'hAAAA;
    bus.wb_write_reg = 1'b1;
    bus.wb_dst_reg   = 4'd3;
    bus.wb_dst_data  = 16'h5555;
    step();
    checks++;
    if (bus.ex_op_a !== 16'h5555) begin
      errors++;
      $display("FAIL bypass_hit: op_a=%h, want 5555", bus.ex_op_a);
    end
    checks++;
    if (bus.ex_op_b !== 16'h2222) begin
      errors++;
      $display("FAIL bypass_other_src: op_b=%h, want 2222", bus.ex_op_b);
    end
    bus.wb_dst_reg = 4'd4;
    step();
    checks++;
    if (bus.ex_op_a !== 16'hAAAA) begin
      errors++;
      $display("FAIL bypass_miss: op_a=%h, want aaaa", bus.ex_op_a);
    end
    // Write-back disabled: address match alone must not bypass
    bus.wb_dst_reg   = 4'd3;
    bus.wb_write_reg = 1'b0;
    step();
    checks++;
    if (bus.ex_op_a !== 16'hAAAA) begin
      errors++;
      $display("FAIL bypass_disabled: op_a=%h, want aaaa", bus.ex_op_a);
    end
  endtask

  task automatic test_zero_reg();
    drive_default();
    bus.id_src_reg2  = 4'd0;
    bus.rf_src_data2 = 16'hFFFF;
    bus.wb_write_reg = 1'b1;
    bus.wb_dst_reg   = 4'd0;
    bus.wb_dst_data  = 16'h7777;
    step();
    checks++;
    if (bus.ex_op_b !== 16'h0000) begin
      errors++;
      $display("FAIL zero_reg_b: op_b=%h, want 0000", bus.ex_op_b);
    end
    checks++;
    if (bus.ex_op_a !== 16'h1111) begin
      errors++;
      $display("FAIL zero_reg_a_unaffected: op_a=%h, want 1111", bus.ex_op_a);
    end
  endtask

  task automatic test_stall_refresh();
    drive_default();
    bus.id_src_reg1  = 4'd5;
    bus.rf_src_data1 = 16'h0001;
    step();
    checks++;
    if (bus.ex_op_a !== 16'h0001) begin
      errors++;
      $display("FAIL stall_setup: op_a=%h, want 0001", bus.ex_op_a);
    end
    // Stall with different ID inputs present; they must not be captured
    bus.stall        = 1'b1;
    bus.id_opcode    = 4'hF;
    bus.id_imm       = 16'hDEAD;
    bus.rf_src_data1 = 16'h9999;
    step();
    checks++;
    if (bus.ex_op_a !== 16'h0001 || bus.ex_opcode !== 4'h1 || bus.ex_imm !== 16'h0010) begin
      errors++;
      $display("FAIL stall_hold1: op_a=%h opc=%h imm=%h, want 0001 1 0010",
               bus.ex_op_a, bus.ex_opcode, bus.ex_imm);
    end
    bus.wb_write_reg = 1'b1;
    bus.wb_dst_reg   = 4'd5;
    bus.wb_dst_data  = 16'h0BEE;
    step();
    checks++;
    if (bus.ex_op_a !== 16'h0BEE) begin
      errors++;
      $display("FAIL stall_refresh: op_a=%h, want 0bee", bus.ex_op_a);
    end
    checks++;
    if (bus.ex_op_b !== 16'h2222) begin
      errors++;
      $display("FAIL stall_refresh_b_held: op_b=%h, want 2222", bus.ex_op_b);
    end
    bus.wb_write_reg = 1'b0;
    step();
    checks++;
    if (bus.ex_op_a !== 16'h0BEE || bus.ex_valid !== 1'b1 || bus.ex_src_reg1 !== 4'd5 ||
        bus.ex_dst_reg !== 4'd3 || bus.ex_pc_plus2 !== 16'h0100 ||
        bus.ex_write_reg !== 1'b1 || bus.ex_opcode !== 4'h1) begin
      errors++;
      $display("FAIL stall_hold3: op_a=%h valid=%b src1=%h dst=%h pc=%h wr=%b opc=%h",
               bus.ex_op_a, bus.ex_valid, bus.ex_src_reg1, bus.ex_dst_reg,
               bus.ex_pc_plus2, bus.ex_write_reg, bus.ex_opcode);
    end
    checks++;
    if (bus.bubble_count !== 16'd0) begin
      errors++;
      $display("FAIL stall_bubble_count: bc=%0d, want 0", bus.bubble_count);
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_flush_over_stall();
    drive_default();
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.bubble_count !== 16'd0) begin
      errors++;
      $display("FAIL flush_setup: valid=%b bc=%0d, want 1 0", bus.ex_valid, bus.bubble_count);
    end
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_write_reg !== 1'b0 || bus.bubble_count !== 16'd1 ||
        bus.ex_opcode !== 4'h0 || bus.ex_op_a !== 16'h0 || bus.ex_imm !== 16'h0) begin
      errors++;
      $display("FAIL flush_over_stall: valid=%b wr=%b bc=%0d opc=%h op_a=%h imm=%h",
               bus.ex_valid, bus.ex_write_reg, bus.bubble_count, bus.ex_opcode,
               bus.ex_op_a, bus.ex_imm);
    end
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    bus.id_valid = 1'b0;
    step();
    checks++;
    if (bus.bubble_count !== 16'd2 || bus.ex_valid !== 1'b0 || bus.ex_write_reg !== 1'b0) begin
      errors++;
      $display("FAIL invalid_load1: bc=%0d valid=%b wr=%b, want 2 0 0",
               bus.bubble_count, bus.ex_valid, bus.ex_write_reg);
    end
    step();
    checks++;
    if (bus.bubble_count !== 16'd3) begin
      errors++;
      $display("FAIL invalid_load2: bc=%0d, want 3", bus.bubble_count);
    end
    // Stalling a bubble holds it without counting, even with a write-back to r0
    bus.stall        = 1'b1;
    bus.wb_write_reg = 1'b1;
    bus.wb_dst_reg   = 4'd0;
    bus.wb_dst_data  = 16'h4444;
    step();
    checks++;
    if (bus.bubble_count !== 16'd3 || bus.ex_valid !== 1'b0 || bus.ex_op_a !== 16'h0) begin
      errors++;
      $display("FAIL stall_bubble: bc=%0d valid=%b op_a=%h, want 3 0 0000",
               bus.bubble_count, bus.ex_valid, bus.ex_op_a);
    end
    drive_default();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    checks++;
    if (bus2.bubble_count !== 2'd0) begin
      errors++;
      $display("FAIL sat_start: bc=%0d, want 0", bus2.bubble_count);
    end
    bus2.flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus2.bubble_count !== exp_seq[i]) begin
        errors++;
        $display("FAIL sat_flush%0d: bc=%0d, want %0d", i, bus2.bubble_count, exp_seq[i]);
      end
    end
    bus2.flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_stall_refresh();
    test_flush_over_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
